// File: rtl/zamarine_pkg.sv
// Shared types and constants for the zamarine component sequencer.
package zamarine_pkg;

    localparam int unsigned CMD_ID_W               = 3;
    localparam int unsigned MAX_COMPONENTS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/zamarine_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in mask, found when mask != 0.
module zamarine_prio_enc
    import zamarine_pkg::*;
#(
    parameter int unsigned W = MAX_COMPONENTS_DEFAULT
) (
    input  logic [W-1:0]        mask,
    output logic [CMD_ID_W-1:0] index,
    output logic                found
);

    // Descending scan so the lowest set bit wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = CMD_ID_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zamarine_component_sequencer.sv
// Drives a component bank from its status bitmap to a requested target mask, one component at a time.
// ZAMARINE_SEQ_VERIFY_EN adds per-command WAIT/readback with timeout; default build issues commands back to back.
module zamarine_component_sequencer
    import zamarine_pkg::*;
#(
    parameter int unsigned MAX_COMPONENTS = MAX_COMPONENTS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic [MAX_COMPONENTS-1:0] req_mask,
    output logic                      req_ready,
    input  logic [MAX_COMPONENTS-1:0] status,
    output logic [CMD_ID_W-1:0]       cmd_id,
    output logic                      cmd_activate,
    output logic                      cmd_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [CMD_ID_W-1:0]       err_id
);

    localparam int unsigned N = MAX_COMPONENTS;

    if (MAX_COMPONENTS < 2 || MAX_COMPONENTS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("zamarine_component_sequencer: parameter out of legal range");
    end

    seq_state_t          state_q, state_d;
    logic [N-1:0]        target_q, target_d;
    logic [CMD_ID_W-1:0] cmd_id_q, cmd_id_d;
    logic                cmd_act_q, cmd_act_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                done_q, done_d;
    logic                req_ready_q;
    logic                busy_q;

    logic [N-1:0]        scan_mask;
    logic [CMD_ID_W-1:0] pick_id;
    logic                pick_found;
    logic [N-1:0]        pick_bit;

`ifdef ZAMARINE_SEQ_VERIFY_EN
    localparam int unsigned TIMER_W = 8;

    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                error_q, error_d;
    logic [CMD_ID_W-1:0] err_id_q, err_id_d;
    logic [N-1:0]        cmd_bit;
    logic                status_match;

    assign scan_mask    = status ^ target_q;
    assign cmd_bit      = N'(1) << cmd_id_q;
    assign status_match = ((status & cmd_bit) != '0) == cmd_act_q;
`else
    // Remaining commands; the diff is snapshotted on the first SCAN cycle only.
    logic [N-1:0]        pending_q, pending_d;
    logic                first_q, first_d;

    assign scan_mask = first_q ? (status ^ target_q) : pending_q;
`endif

    zamarine_prio_enc #(.W(N)) u_prio_enc (
        .mask  (scan_mask),
        .index (pick_id),
        .found (pick_found)
    );

    assign pick_bit = N'(1) << pick_id;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        cmd_id_d    = cmd_id_q;
        cmd_act_d   = cmd_act_q;
        cmd_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef ZAMARINE_SEQ_VERIFY_EN
        timer_d     = timer_q;
        error_d     = 1'b0;
        err_id_d    = err_id_q;
`else
        pending_d   = pending_q;
        first_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    target_d = req_mask;
                    state_d  = SCAN;
`ifndef ZAMARINE_SEQ_VERIFY_EN
                    first_d  = 1'b1;
`endif
                end
            end
            SCAN: begin
                if (pick_found) begin
                    cmd_id_d    = pick_id;
                    cmd_act_d   = (target_q & pick_bit) != '0;
                    cmd_valid_d = 1'b1;
`ifdef ZAMARINE_SEQ_VERIFY_EN
                    timer_d     = '0;
                    state_d     = WAIT;
`else
                    pending_d   = scan_mask & ~pick_bit;
`endif
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef ZAMARINE_SEQ_VERIFY_EN
            WAIT: begin
                // A matching readback wins over an expiring timer.
                if (status_match) begin
                    state_d = SCAN;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d  = 1'b1;
                    err_id_d = cmd_id_q;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= '0;
            cmd_id_q    <= '0;
            cmd_act_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef ZAMARINE_SEQ_VERIFY_EN
            timer_q     <= '0;
            error_q     <= 1'b0;
            err_id_q    <= '0;
`else
            pending_q   <= '0;
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cmd_id_q    <= cmd_id_d;
            cmd_act_q   <= cmd_act_d;
            cmd_valid_q <= cmd_valid_d;
            done_q      <= done_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
`ifdef ZAMARINE_SEQ_VERIFY_EN
            timer_q     <= timer_d;
            error_q     <= error_d;
            err_id_q    <= err_id_d;
`else
            pending_q   <= pending_d;
            first_q     <= first_d;
`endif
        end
    end

    assign req_ready    = req_ready_q;
    assign cmd_id       = cmd_id_q;
    assign cmd_activate = cmd_act_q;
    assign cmd_valid    = cmd_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef ZAMARINE_SEQ_VERIFY_EN
    assign error        = error_q;
    assign err_id       = err_id_q;
`else
    assign error        = 1'b0;
    assign err_id       = '0;
`endif

endmodule

// File: tb/tb_zamarine_component_sequencer.sv
// Directed bench for zamarine_component_sequencer with a small component-bank model.
module tb_zamarine_component_sequencer;

    localparam int unsigned N = 8;
`ifdef ZAMARINE_SEQ_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [N-1:0] req_mask;
    logic         req_ready;
    logic [N-1:0] status;
    logic [2:0]   cmd_id;
    logic         cmd_activate;
    logic         cmd_valid;
    logic         busy;
    logic         done;
    logic         error;
    logic [2:0]   err_id;

    int errors = 0;
    int checks = 0;
    bit ignore3 = 1'b0;
    int rec_id[$];
    int rec_act[$];
    int rec_cyc[$];
    int done_cnt;
    int err_cnt;
    int done_cyc;
    int end_cyc;

    always #5 clk = ~clk;

    zamarine_component_sequencer #(
        .MAX_COMPONENTS (N),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_mask     (req_mask),
        .req_ready    (req_ready),
        .status       (status),
        .cmd_id       (cmd_id),
        .cmd_activate (cmd_activate),
        .cmd_valid    (cmd_valid),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_id       (err_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // One clock; the bank applies the command that was visible before the edge.
    task automatic tick();
        logic       cv;
        logic [2:0] id;
        logic       act;
        cv  = cmd_valid;
        id  = cmd_id;
        act = cmd_activate;
        @(posedge clk);
        #1;
        if (cv && !(ignore3 && id == 3'd3)) status[id] = act;
    endtask

    task automatic clear_rec();
        rec_id.delete();
        rec_act.delete();
        rec_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
        end_cyc  = -1;
    endtask

    task automatic record(input int c);
        if (cmd_valid) begin
            rec_id.push_back(int'(cmd_id));
            rec_act.push_back(int'(cmd_activate));
            rec_cyc.push_back(c);
        end
        if (done) begin
            done_cnt++;
            done_cyc = c;
        end
        if (error) err_cnt++;
    endtask

    // Offer one mask, then watch until busy drops (cycle numbers count from the accepting edge).
    task automatic run_req(input logic [N-1:0] mask, input int bound);
        int c;
        clear_rec();
        req_mask  = mask;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        c = 0;
        do begin
            tick();
            c++;
            record(c);
        end while (busy && c < bound);
        end_cyc = c;
        chk("settle_busy", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int  c;
        bit  drop;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_mask  = '0;
        status    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Idle after reset
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_id", 32'(err_id), 0);
        chk("rst_cmd_id", 32'(cmd_id), 0);
        chk("rst_cmd_act", 32'(cmd_activate), 0);
        chk("rst_cmd_valid", 32'(cmd_valid), 0);

        // 0x05 from all-off
        status = '0;
        run_req(8'h05, 60);
        chk("m05_ncmd", 32'(rec_id.size()), 2);
        chk("m05_id0", 32'(q_at(rec_id, 0)), 0);
        chk("m05_act0", 32'(q_at(rec_act, 0)), 1);
        chk("m05_id1", 32'(q_at(rec_id, 1)), 2);
        chk("m05_act1", 32'(q_at(rec_act, 1)), 1);
        chk("m05_done_cnt", 32'(done_cnt), 1);
        chk("m05_done_cyc", 32'(done_cyc), VERIFY ? 7 : 3);
        chk("m05_err_cnt", 32'(err_cnt), 0);
        chk("m05_status", 32'(status), 32'h05);
        repeat (2) tick();
        chk("m05_hold_id", 32'(cmd_id), 2);
        chk("m05_hold_act", 32'(cmd_activate), 1);
        chk("m05_hold_valid", 32'(cmd_valid), 0);

        // Already at target
        status = 8'h3C;
        run_req(8'h3C, 20);
        chk("m3c_ncmd", 32'(rec_id.size()), 0);
        chk("m3c_done_cnt", 32'(done_cnt), 1);
        chk("m3c_done_cyc", 32'(done_cyc), 1);
        chk("m3c_status", 32'(status), 32'h3C);

        // Component 3 never responds
        status  = '0;
        ignore3 = 1'b1;
        run_req(8'h08, 60);
        chk("to_ncmd", 32'(rec_id.size()), 1);
        chk("to_id", 32'(q_at(rec_id, 0)), 3);
        chk("to_err_cnt", 32'(err_cnt), VERIFY ? 1 : 0);
        chk("to_done_cnt", 32'(done_cnt), VERIFY ? 0 : 1);
        chk("to_end_cyc", 32'(end_cyc), VERIFY ? 16 : 2);
        chk("to_err_id", 32'(err_id), VERIFY ? 3 : 0);
        repeat (3) tick();
        chk("to_err_id_hold", 32'(err_id), VERIFY ? 3 : 0);
        chk("to_error_low", 32'(error), 0);
        ignore3 = 1'b0;

        // Offer held while busy with a different mask
        clear_rec();
        status    = '0;
        req_mask  = 8'h01;
        req_valid = 1'b1;
        tick();
        req_mask = 8'hFF;
        c    = 0;
        drop = 1'b0;
        do begin
            tick();
            c++;
            if (drop) req_valid = 1'b0;
            record(c);
            if (c == 1) chk("hold_ready_busy", 32'(req_ready), 0);
            if (req_valid && req_ready) drop = 1'b1;
        end while (!(done_cnt == 2 && !busy) && c < 200);
        req_valid = 1'b0;
        chk("hold_done_cnt", 32'(done_cnt), 2);
        chk("hold_ncmd", 32'(rec_id.size()), 8);
        chk("hold_first_id", 32'(q_at(rec_id, 0)), 0);
        chk("hold_second_id", 32'(q_at(rec_id, 1)), 1);
        chk("hold_last_id", 32'(q_at(rec_id, 7)), 7);
        chk("hold_status", 32'(status), 32'hFF);

        // Reset in the middle of a request
        clear_rec();
        status    = '0;
        req_mask  = 8'hF0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 1);
        chk("mid_cmd_valid", 32'(cmd_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        chk("mid_rst_cmd_valid", 32'(cmd_valid), 0);
        chk("mid_rst_cmd_id", 32'(cmd_id), 0);
        for (int k = 1; k <= 20; k++) begin
            record(k);
            tick();
        end
        chk("mid_no_done", 32'(done_cnt), 0);
        chk("mid_no_error", 32'(err_cnt), 0);

        // Full mask from all-off
        status = '0;
        run_req(8'hFF, 100);
        chk("ff_ncmd", 32'(rec_id.size()), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ff_id%0d", i), 32'(q_at(rec_id, i)), 32'(i));
            chk($sformatf("ff_cyc%0d", i), 32'(q_at(rec_cyc, i)), VERIFY ? 32'(1 + 3 * i) : 32'(1 + i));
        end
        chk("ff_done_cnt", 32'(done_cnt), 1);
        chk("ff_status", 32'(status), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
